// File: rtl/fire_scheduler.sv
// Transition-firing controller: picks one excited model transition per step
// (round-robin, LFSR or directed) and drives its index on fire for one cycle.
module fire_scheduler #(
  parameter int          N         = 8,
  parameter int          W         = $clog2(N+1),
  parameter int          CW        = 16,
  parameter int          MAX_STEPS = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [1:0]    mode,
  input  logic [15:0]   seed,
  input  logic          seed_load,
  input  logic [W-1:0]  ext_fire,
  input  logic          ext_valid,
  input  logic [N-1:0]  excited,
  output logic [W-1:0]  fire,
  output logic          fired,
  output logic          deadlock,
  output logic          dir_err,
  output logic          done,
  output logic [CW-1:0] step_count
);

  localparam logic [W-1:0] NONE = W'(N);

  typedef enum logic [1:0] {S_IDLE, S_PICK, S_FIRE, S_DEAD} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  fire_q, fire_d;
  logic          fired_q, fired_d;
  logic          deadlock_q, deadlock_d;
  logic          dir_err_q, dir_err_d;
  logic          done_q, done_d;
  logic [CW-1:0] step_q, step_d;
  logic [W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [15:0]   lfsr_q, lfsr_d;

  logic [15:0]   lfsr_shift;
  logic [W-1:0]  start;
  logic [W:0]    pick;
  logic [N-1:0]  ext_sh;
  logic          dir_ok;

  // Returns {found, index} of the first set bit of vec scanning circularly from start.
  function automatic logic [W:0] first_from(input logic [W-1:0] st, input logic [N-1:0] vec);
    logic [2*N-1:0] dbl;
    logic [W:0]     sum;
    logic [W:0]     res;
    dbl = {vec, vec} >> st;
    sum = '0;
    res = '0;
    for (int j = N-1; j >= 0; j--) begin
      if (dbl[j]) begin
        sum = {1'b0, st} + (W+1)'(j);
        if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
        res = {1'b1, sum[W-1:0]};
      end
    end
    return res;
  endfunction

  always_comb begin
    lfsr_shift = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    if (mode == 2'd1) start = (lfsr_q[W-1:0] < NONE) ? lfsr_q[W-1:0] : '0;
    else              start = rr_ptr_q;
    pick   = first_from(start, excited);
    ext_sh = excited >> ext_fire;
    dir_ok = (ext_fire < NONE) && ext_sh[0];
  end

  always_comb begin
    state_d    = state_q;
    fire_d     = fire_q;
    fired_d    = 1'b0;
    deadlock_d = deadlock_q;
    dir_err_d  = dir_err_q;
    done_d     = done_q;
    step_d     = step_q;
    rr_ptr_d   = rr_ptr_q;
    lfsr_d     = lfsr_q;

    if (state_q == S_PICK) lfsr_d = lfsr_shift;
    if (seed_load)         lfsr_d = (seed == 16'h0) ? LFSR_SEED : seed;

    case (state_q)
      S_IDLE: begin
        fire_d = NONE;
        if (run && !done_q) state_d = S_PICK;
      end
      S_PICK: begin
        fire_d = NONE;
        if (!run) begin
          state_d = S_IDLE;
        end else if (mode == 2'd2) begin
          // Directed mode waits for a request; a bad request never stalls into DEAD.
          if (ext_valid) begin
            if (dir_ok) begin
              fire_d  = ext_fire;
              fired_d = 1'b1;
              state_d = S_FIRE;
            end else begin
              dir_err_d = 1'b1;
            end
          end
        end else if (pick[W]) begin
          fire_d  = pick[W-1:0];
          fired_d = 1'b1;
          state_d = S_FIRE;
          if (mode != 2'd1) rr_ptr_d = (pick[W-1:0] == W'(N-1)) ? '0 : pick[W-1:0] + W'(1);
        end else begin
          deadlock_d = 1'b1;
          state_d    = S_DEAD;
        end
      end
      S_FIRE: begin
        fire_d = NONE;
        if (step_q != '1) step_d = step_q + CW'(1);
        if (MAX_STEPS != 0 && step_d == CW'(MAX_STEPS)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (!run) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_PICK;
        end
      end
      default: fire_d = NONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fire_q     <= NONE;
      fired_q    <= 1'b0;
      deadlock_q <= 1'b0;
      dir_err_q  <= 1'b0;
      done_q     <= 1'b0;
      step_q     <= '0;
      rr_ptr_q   <= '0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      state_q    <= state_d;
      fire_q     <= fire_d;
      fired_q    <= fired_d;
      deadlock_q <= deadlock_d;
      dir_err_q  <= dir_err_d;
      done_q     <= done_d;
      step_q     <= step_d;
      rr_ptr_q   <= rr_ptr_d;
      lfsr_q     <= lfsr_d;
    end
  end

  assign fire       = fire_q;
  assign fired      = fired_q;
  assign deadlock   = deadlock_q;
  assign dir_err    = dir_err_q;
  assign done       = done_q;
  assign step_count = step_q;

endmodule
